rr_packet_arbiter: RTL and testbench
====================================

# rr_packet_arbiter

Round-robin arbiter that shares one registered valid/ready stream among NUM_PORTS packet-framed requesters. It sits in front of the skid-buffered pipeline stages and locks the grant for the length of a packet, so beats from different requesters never interleave. The index of the granted port is carried alongside the data. All downstream outputs are registered through an internal skid stage, so the downstream path needs no combinational ready-to-ready path.

## Interface
- DATA_WIDTH, 32, payload width per port
- NUM_PORTS, 4, number of requesters; legal range 2..8
- SEL_WIDTH, $clog2(NUM_PORTS), width of port index (localparam)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- up_bus  in  NUM_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- up_last  in  NUM_PORTS  final beat of packet, per port
- up_val  in  NUM_PORTS  beat valid, per port
- up_rdy  out  NUM_PORTS  beat accepted when up_val[i] & up_rdy[i]
- dn_bus  out  DATA_WIDTH  payload
- dn_last  out  1  final beat of packet
- dn_sel  out  SEL_WIDTH  index of the port that sourced the beat
- dn_val  out  1  downstream valid
- dn_rdy  in  1  downstream ready

## Operation
- Two-state FSM:
  - IDLE: no grant held; all up_rdy are 0.
  - LOCKED: grant register g is held.
- Round-robin pointer ptr, SEL_WIDTH bits.
- In IDLE, if any up_val is set:
  - g <= lowest index k with up_val[k], searching ptr, ptr+1, … modulo NUM_PORTS.
  - Next state is LOCKED.
- In LOCKED, the arbiter presents {up_last[g], g, up_bus slice g} to the internal skid stage:
  - The stage's valid input is up_val[g].
  - up_rdy[g] equals the stage's registered ready.
  - All other up_rdy bits are 0.
- When a beat with up_last[g]=1 is accepted (up_val[g] & up_rdy[g]):
  - Next state is IDLE.
  - ptr <= (g+1) mod NUM_PORTS; wrap from NUM_PORTS-1 to 0.
  - ptr changes only at this event.
- Single-beat packets are legal: the first beat has up_last=1.
- Requester obligations: hold up_bus and up_last stable while up_val & ~up_rdy, and do not drop up_val without a handshake. The arbiter does not check these.
- Downstream guarantees:
  - dn_bus, dn_last and dn_sel stay stable while dn_val & ~dn_rdy.
  - dn_val falls only after a handshake.
  - No beat is dropped or duplicated.
- Ports not granted see up_rdy=0 regardless of dn_rdy.

## Timing
- Reset values: up_rdy all 0, dn_val 0, FSM IDLE, ptr 0.
  - dn_bus, dn_last and dn_sel are don't-care until the first dn_val.
- Reset asserted mid-packet: on the next edge, the FSM goes to IDLE, ptr to 0 and dn_val to 0. In-flight beats are discarded.
- Arbitration latency: up_val rises in cycle 0 while IDLE.
  - Cycle 1: g registered, state LOCKED; up_rdy[g] is high if the stage is ready.
  - Cycle 1: beat accepted.
  - Cycle 2: dn_val=1.
- Throughput within a packet: 1 beat/cycle while dn_rdy=1.
- Packet boundary: the cycle after the last beat is accepted is an IDLE arbitration cycle, giving one bubble between consecutive packets.
- Backpressure:
  - The skid stage absorbs one extra beat after dn_rdy falls.
  - up_rdy[g] falls within one cycle of the stall.
  - On dn_rdy rising, the skid beat drains first, then forwarding resumes.
- Simultaneous last-beat acceptance and a new request from any port: the new request is arbitrated in the following IDLE cycle using the updated ptr.

## Structure
- Shared package: FSM state encoding (IDLE, LOCKED) and the NUM_PORTS legality bound.
- One sub-module: skid_register.
  - Instantiated with DATA_WIDTH = DATA_WIDTH+SEL_WIDTH+1.
  - Carries {last, sel, bus}.
  - Provides the registered up_rdy and the downstream output registers.
- Arbiter logic in the top module: FSM, ptr, rotate-priority search, input mux.

## Test plan
- Port 1 alone sends a 3-beat packet 0xA,0xB,0xC with dn_rdy=1 -> dn_bus 0xA,0xB,0xC on consecutive cycles; dn_sel=1 on every beat; dn_last only on 0xC; first dn_val 2 cycles after up_val.
- After reset, all four ports each hold one single-beat packet -> output order ports 0,1,2,3, with one bubble cycle between beats.
- Port 0 sends a 4-beat packet while port 1 is already valid -> all 4 port-0 beats precede any port-1 beat; up_rdy[1]=0 throughout.
- dn_rdy=0 for 5 cycles mid-packet -> dn_bus stable during the stall; exactly one extra beat absorbed; upon release the full sequence is output with no loss or repeat.
- rst pulsed during beat 2 of a port-3 packet -> next cycle up_rdy=0 and dn_val=0; after release, a port-2-only request produces dn_sel=2 at the standard 2-cycle latency.
- A port-2 packet completes (ptr=3), then ports 0 and 3 request together -> port 3 is served first, then port 0.

Source files
------------

// File: rtl/rr_packet_arbiter_pkg.sv
// Shared definitions for the round-robin packet arbiter.
// Holds the FSM state encoding and the legal port-count range.
package rr_packet_arbiter_pkg;

    localparam int MIN_PORTS = 2;
    localparam int MAX_PORTS = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_packet_arbiter_skid_register.sv
// Two-entry skid register for a valid/ready stream.
// Ports: clk, rst (sync, active-high); in_data/in_val/in_rdy upstream;
//        out_data/out_val/out_rdy downstream. in_rdy and all out_* are
//        driven straight from flops, so no ready path passes through.
module skid_register #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_val,
    input  logic                  out_rdy
);

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_val;
    logic                  load_out;

    // Upstream may send whenever the spare slot is empty.
    assign in_rdy   = ~skid_val;
    assign load_out = ~out_val | out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_val  <= 1'b0;
            skid_val <= 1'b0;
        end else if (load_out) begin
            if (skid_val) begin
                // Drain the parked beat before taking new input.
                out_data <= skid_data;
                out_val  <= 1'b1;
                skid_val <= 1'b0;
            end else begin
                out_val <= in_val;
                if (in_val) begin
                    out_data <= in_data;
                end
            end
        end else if (in_val && !skid_val) begin
            // Output stalled: park the beat that was already in flight.
            skid_data <= in_data;
            skid_val  <= 1'b1;
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: grants one requester per packet and
// forwards {last, sel, bus} through a skid register to one stream.
// Ports: clk, rst (sync, active-high); up_bus/up_last/up_val/up_rdy per
//        requester; dn_bus/dn_last/dn_sel/dn_val/dn_rdy downstream.
module rr_packet_arbiter
    import rr_packet_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_PORTS  = 4,
    localparam int SEL_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] up_bus,
    input  logic [NUM_PORTS-1:0]          up_last,
    input  logic [NUM_PORTS-1:0]          up_val,
    output logic [NUM_PORTS-1:0]          up_rdy,
    output logic [DATA_WIDTH-1:0]         dn_bus,
    output logic                          dn_last,
    output logic [SEL_WIDTH-1:0]          dn_sel,
    output logic                          dn_val,
    input  logic                          dn_rdy
);

    localparam int PW = DATA_WIDTH + SEL_WIDTH + 1;

    if (NUM_PORTS < MIN_PORTS || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
        $error("rr_packet_arbiter: NUM_PORTS out of range");
    end

    arb_state_t           state;
    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] g;
    logic [SEL_WIDTH-1:0] pick;
    logic                 found;
    int                   j;

    logic                 locked;
    logic                 stg_val;
    logic                 stg_rdy;
    logic                 fire;
    logic [PW-1:0]        stg_data;
    logic [PW-1:0]        dn_data;

    // First requester at or after ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = (int'(ptr) + i) % NUM_PORTS;
            if (!found && up_val[j]) begin
                found = 1'b1;
                pick  = SEL_WIDTH'(j);
            end
        end
    end

    assign locked   = (state == LOCKED);
    assign stg_val  = locked & up_val[g];
    assign fire     = stg_val & stg_rdy;
    assign stg_data = {up_last[g], g,
                       up_bus[g*DATA_WIDTH +: DATA_WIDTH]};
    assign up_rdy   = locked ? (NUM_PORTS'(stg_rdy) << g) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            g     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        g     <= pick;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (fire && up_last[g]) begin
                        state <= IDLE;
                        ptr   <= (g == SEL_WIDTH'(NUM_PORTS - 1))
                                 ? '0 : g + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    skid_register #(
        .DATA_WIDTH(PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_data (stg_data),
        .in_val  (stg_val),
        .in_rdy  (stg_rdy),
        .out_data(dn_data),
        .out_val (dn_val),
        .out_rdy (dn_rdy)
    );

    assign dn_bus  = dn_data[DATA_WIDTH-1:0];
    assign dn_sel  = dn_data[DATA_WIDTH +: SEL_WIDTH];
    assign dn_last = dn_data[PW-1];

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter (4 ports, 32-bit payload).
// Per-port beat queues act as well-behaved requesters.
module tb_rr_packet_arbiter;

    localparam int DW = 32;
    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*DW-1:0] up_bus;
    logic [NP-1:0]   up_last;
    logic [NP-1:0]   up_val;
    logic [NP-1:0]   up_rdy;
    logic [DW-1:0]   dn_bus;
    logic            dn_last;
    logic [1:0]      dn_sel;
    logic            dn_val;
    logic            dn_rdy;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] mem [NP][16];
    int          hd  [NP];
    int          tl  [NP];

    always #5 clk = ~clk;

    rr_packet_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_PORTS (NP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .up_bus (up_bus),
        .up_last(up_last),
        .up_val (up_val),
        .up_rdy (up_rdy),
        .dn_bus (dn_bus),
        .dn_last(dn_last),
        .dn_sel (dn_sel),
        .dn_val (dn_val),
        .dn_rdy (dn_rdy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (hd[p] < tl[p]) begin
                up_val[p]           = 1'b1;
                up_last[p]          = mem[p][hd[p]][32];
                up_bus[p*DW +: DW]  = mem[p][hd[p]][31:0];
            end else begin
                up_val[p]           = 1'b0;
                up_last[p]          = 1'b0;
                up_bus[p*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic flush();
        for (int p = 0; p < NP; p++) begin
            hd[p] = 0;
            tl[p] = 0;
        end
        drive();
    endtask

    task automatic load(input int p, input logic [31:0] d,
                        input logic last);
        mem[p][tl[p]] = {last, d};
        tl[p]++;
    endtask

    task automatic tick();
        logic [NP-1:0] hs;
        hs = up_val & up_rdy;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) hd[p]++;
        end
        drive();
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d,
                            input logic [1:0] s, input logic l);
        chk({tag, "_val"},  32'(dn_val),  32'd1);
        chk({tag, "_bus"},  dn_bus,       d);
        chk({tag, "_sel"},  32'(dn_sel),  32'(s));
        chk({tag, "_last"}, 32'(dn_last), 32'(l));
    endtask

    initial begin
        rst    = 1'b1;
        dn_rdy = 1'b1;
        flush();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_up_rdy", 32'(up_rdy), 32'h0);
        chk("rst_dn_val", 32'(dn_val), 32'h0);

        // Port 1 alone, 3 beats.
        load(1, 32'hA, 1'b0);
        load(1, 32'hB, 1'b0);
        load(1, 32'hC, 1'b1);
        drive();
        chk("t1_c0_up_rdy", 32'(up_rdy), 32'h0);
        tick();
        chk("t1_c1_up_rdy", 32'(up_rdy), 32'h2);
        chk("t1_c1_dn_val", 32'(dn_val), 32'h0);
        tick();
        chk_beat("t1_b0", 32'hA, 2'd1, 1'b0);
        tick();
        chk_beat("t1_b1", 32'hB, 2'd1, 1'b0);
        tick();
        chk_beat("t1_b2", 32'hC, 2'd1, 1'b1);
        chk("t1_idle_up_rdy", 32'(up_rdy), 32'h0);
        tick();
        chk("t1_end_dn_val", 32'(dn_val), 32'h0);

        // Reset, then all ports with single-beat packets.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t2_rst_dn_val", 32'(dn_val), 32'h0);
        for (int p = 0; p < NP; p++) load(p, 32'h10 + p, 1'b1);
        drive();
        for (int p = 0; p < NP; p++) begin
            tick();
            chk("t2_bubble_val", 32'(dn_val), 32'h0);
            chk("t2_grant", 32'(up_rdy), 32'(1 << p));
            tick();
            chk_beat("t2_beat", 32'h10 + p, 2'(p), 1'b1);
        end

        // Port 0 four beats while port 1 already waits.
        load(1, 32'h21, 1'b1);
        for (int b = 0; b < 4; b++) load(0, 32'h30 + b, b == 3);
        drive();
        tick();
        chk("t3_grant0", 32'(up_rdy), 32'h1);
        for (int b = 0; b < 4; b++) begin
            tick();
            chk_beat("t3_p0", 32'h30 + b, 2'd0, b == 3);
            chk("t3_up_rdy1", 32'(up_rdy[1]), 32'h0);
        end
        tick();
        chk("t3_bubble_val", 32'(dn_val), 32'h0);
        chk("t3_grant1", 32'(up_rdy), 32'h2);
        tick();
        chk_beat("t3_p1", 32'h21, 2'd1, 1'b1);

        // Port 2 six beats with a 5-cycle downstream stall.
        for (int b = 0; b < 6; b++) load(2, 32'h40 + b, b == 5);
        drive();
        tick();
        chk("t4_grant2", 32'(up_rdy), 32'h4);
        tick();
        chk_beat("t4_b0", 32'h40, 2'd2, 1'b0);
        tick();
        chk_beat("t4_b1", 32'h41, 2'd2, 1'b0);
        dn_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_beat("t4_stall", 32'h41, 2'd2, 1'b0);
            chk("t4_stall_up_rdy", 32'(up_rdy), 32'h0);
        end
        dn_rdy = 1'b1;
        for (int b = 2; b < 6; b++) begin
            tick();
            chk_beat("t4_drain", 32'h40 + b, 2'd2, b == 5);
        end
        tick();
        chk("t4_end_dn_val", 32'(dn_val), 32'h0);

        // ptr now 3: ports 0 and 3 together, 3 wins.
        load(0, 32'h50, 1'b1);
        load(3, 32'h53, 1'b1);
        drive();
        tick();
        chk("t6_grant3", 32'(up_rdy), 32'h8);
        tick();
        chk_beat("t6_first", 32'h53, 2'd3, 1'b1);
        tick();
        chk("t6_grant0", 32'(up_rdy), 32'h1);
        chk("t6_bubble_val", 32'(dn_val), 32'h0);
        tick();
        chk_beat("t6_second", 32'h50, 2'd0, 1'b1);

        // Reset during beat 2 of a port-3 packet.
        load(3, 32'h60, 1'b0);
        load(3, 32'h61, 1'b0);
        load(3, 32'h62, 1'b1);
        drive();
        tick();
        chk("t5_grant3", 32'(up_rdy), 32'h8);
        tick();
        chk_beat("t5_b0", 32'h60, 2'd3, 1'b0);
        rst = 1'b1;
        tick();
        chk("t5_rst_up_rdy", 32'(up_rdy), 32'h0);
        chk("t5_rst_dn_val", 32'(dn_val), 32'h0);
        rst = 1'b0;
        flush();
        load(2, 32'h72, 1'b1);
        drive();
        tick();
        chk("t5_grant2", 32'(up_rdy), 32'h4);
        chk("t5_lat1_val", 32'(dn_val), 32'h0);
        tick();
        chk_beat("t5_p2", 32'h72, 2'd2, 1'b1);
        tick();
        chk("t5_end_dn_val", 32'(dn_val), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
